// File: rtl/argmax_pkg.sv
// Shared FP16 types, constants and ordering helpers for the argmax stage sequencer.
package argmax_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_NEG_INF = 16'hFC00;
  localparam fp16_t FP16_098     = 16'h3BD7;

  function automatic logic fp16_is_nan(input fp16_t a);
    return (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
  endfunction

  // Sign-magnitude mapped onto a signed integer line; +0 and -0 both land on 0.
  function automatic logic signed [16:0] fp16_key(input fp16_t a);
    logic signed [16:0] mag;
    mag = {2'b00, a[14:0]};
    return a[15] ? -mag : mag;
  endfunction

  function automatic logic fp16_gt(input fp16_t a, input fp16_t b);
    if (fp16_is_nan(a) || fp16_is_nan(b)) begin
      return 1'b0;
    end
    return fp16_key(a) > fp16_key(b);
  endfunction

endpackage

// File: rtl/argmax_stage_seq_if.sv
// Beat/result handshake bundle for argmax_stage_seq.
// The global-max outputs exist only when ARGMAX_GLOBAL_EN is defined.
interface argmax_stage_seq_if #(
  parameter int LANES      = 2,
  parameter int WIDTH      = 16,
  parameter int IDX_W      = 16,
  parameter int STEP_W     = 8,
  parameter int NUM_STAGES = 7
) ();

  localparam int STG_W = $clog2(NUM_STAGES + 1);

  logic [NUM_STAGES*STEP_W-1:0] stage_boundary_i;
  logic [WIDTH-1:0]             thresh_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [LANES*WIDTH-1:0]       score_i;
  logic [LANES*IDX_W-1:0]       pos_i;
  logic [STG_W-1:0]             stage_o;
  logic [STEP_W-1:0]            step_o;
  logic                         result_valid_o;
  logic                         result_ready_i;
  logic [LANES*WIDTH-1:0]       max_o;
  logic [LANES*IDX_W-1:0]       idx_o;
  logic [LANES-1:0]             hit_o;

`ifdef ARGMAX_GLOBAL_EN
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WIDTH-1:0]  gmax_o;
  logic [IDX_W-1:0]  gidx_o;
  logic [LANE_W-1:0] glane_o;

  modport slave (
    input  stage_boundary_i, thresh_i, in_valid_i, score_i, pos_i, result_ready_i,
    output in_ready_o, stage_o, step_o, result_valid_o, max_o, idx_o, hit_o,
    output gmax_o, gidx_o, glane_o
  );

  modport master (
    output stage_boundary_i, thresh_i, in_valid_i, score_i, pos_i, result_ready_i,
    input  in_ready_o, stage_o, step_o, result_valid_o, max_o, idx_o, hit_o,
    input  gmax_o, gidx_o, glane_o
  );
`else
  modport slave (
    input  stage_boundary_i, thresh_i, in_valid_i, score_i, pos_i, result_ready_i,
    output in_ready_o, stage_o, step_o, result_valid_o, max_o, idx_o, hit_o
  );

  modport master (
    output stage_boundary_i, thresh_i, in_valid_i, score_i, pos_i, result_ready_i,
    input  in_ready_o, stage_o, step_o, result_valid_o, max_o, idx_o, hit_o
  );
`endif

endinterface

// File: rtl/argmax_lane.sv
// One score lane: running FP16 maximum and its position during the tracking stage.
module argmax_lane
  import argmax_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_beat,
  input  logic [WIDTH-1:0] i_score,
  input  logic [IDX_W-1:0] i_pos,
  output logic [WIDTH-1:0] o_max,
  output logic [IDX_W-1:0] o_idx
);

  logic [WIDTH-1:0] r_max;
  logic [IDX_W-1:0] r_idx;
  logic             r_entered;
  logic             w_nan;
  logic             w_gt;

  assign w_nan = fp16_is_nan(fp16_t'(i_score));
  assign w_gt  = fp16_gt(fp16_t'(i_score), fp16_t'(r_max));

  // The first tracked beat seeds the max unconditionally so a stale -inf never wins a tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_max     <= WIDTH'(FP16_NEG_INF);
      r_idx     <= '0;
      r_entered <= 1'b0;
    end else if (i_clear) begin
      r_max     <= WIDTH'(FP16_NEG_INF);
      r_idx     <= '0;
      r_entered <= 1'b0;
    end else if (i_beat) begin
      r_entered <= 1'b1;
      if (!r_entered) begin
        r_max <= w_nan ? WIDTH'(FP16_NEG_INF) : i_score;
        r_idx <= i_pos;
      end else if (w_gt) begin
        r_max <= i_score;
        r_idx <= i_pos;
      end
    end
  end

  assign o_max = r_max;
  assign o_idx = r_idx;

endmodule

// File: rtl/argmax_stage_seq.sv
// Step/stage sequencer with per-lane running argmax and result handshake.
// Define ARGMAX_GLOBAL_EN to add the registered cross-lane maximum outputs.
module argmax_stage_seq
  import argmax_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int WIDTH       = 16,
  parameter int IDX_W       = 16,
  parameter int STEP_W      = 8,
  parameter int NUM_STAGES  = 7,
  parameter int TRACK_STAGE = 5
) (
  input logic          CLK_i,
  input logic          RST_i,
  argmax_stage_seq_if.slave bus
);

  localparam int STG_W = $clog2(NUM_STAGES + 1);

  logic [STEP_W-1:0] r_step;
  logic [STG_W-1:0]  w_stage;
  logic              w_final;
  logic              w_accept;
  logic              w_restart;
  logic              w_track_beat;
  logic              w_result_valid;
  logic [WIDTH-1:0]  w_max [LANES];
  logic [IDX_W-1:0]  w_idx [LANES];

  // Counting exceeded boundaries keeps the stage defined for non-monotonic tables.
  always_comb begin
    w_stage = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (r_step > bus.stage_boundary_i[k*STEP_W +: STEP_W]) begin
        w_stage = w_stage + STG_W'(1);
      end
    end
  end

  assign w_final      = (w_stage == STG_W'(NUM_STAGES));
  assign w_accept     = bus.in_valid_i && !w_final;
  assign w_restart    = w_result_valid && bus.result_ready_i;
  assign w_track_beat = w_accept && (w_stage == STG_W'(TRACK_STAGE));

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_step <= '0;
    end else if (w_restart) begin
      r_step <= '0;
    end else if (w_accept && (r_step != {STEP_W{1'b1}})) begin
      r_step <= r_step + STEP_W'(1);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    argmax_lane #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .i_clk   (CLK_i),
      .i_rst   (RST_i),
      .i_clear (w_restart),
      .i_beat  (w_track_beat),
      .i_score (bus.score_i[g*WIDTH +: WIDTH]),
      .i_pos   (bus.pos_i[g*IDX_W +: IDX_W]),
      .o_max   (w_max[g]),
      .o_idx   (w_idx[g])
    );
  end

`ifdef ARGMAX_GLOBAL_EN
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WIDTH-1:0]  w_gmax;
  logic [IDX_W-1:0]  w_gidx;
  logic [LANE_W-1:0] w_glane;
  logic [WIDTH-1:0]  r_gmax;
  logic [IDX_W-1:0]  r_gidx;
  logic [LANE_W-1:0] r_glane;
  logic              r_final_d;

  // Strict compare so the lowest lane keeps ties.
  always_comb begin
    w_gmax  = w_max[0];
    w_gidx  = w_idx[0];
    w_glane = '0;
    for (int i = 1; i < LANES; i++) begin
      if (fp16_gt(fp16_t'(w_max[i]), fp16_t'(w_gmax))) begin
        w_gmax  = w_max[i];
        w_gidx  = w_idx[i];
        w_glane = LANE_W'(i);
      end
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_gmax    <= WIDTH'(FP16_NEG_INF);
      r_gidx    <= '0;
      r_glane   <= '0;
      r_final_d <= 1'b0;
    end else begin
      r_gmax    <= w_gmax;
      r_gidx    <= w_gidx;
      r_glane   <= w_glane;
      r_final_d <= w_final;
    end
  end

  // Results are offered only once the registered reduction has caught up.
  assign w_result_valid = w_final && r_final_d;
  assign bus.gmax_o     = r_gmax;
  assign bus.gidx_o     = r_gidx;
  assign bus.glane_o    = r_glane;
`else
  assign w_result_valid = w_final;
`endif

  always_comb begin
    bus.max_o = '0;
    bus.idx_o = '0;
    bus.hit_o = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.max_o[i*WIDTH +: WIDTH] = w_max[i];
      bus.idx_o[i*IDX_W +: IDX_W] = w_idx[i];
      bus.hit_o[i]                = fp16_gt(fp16_t'(w_max[i]), fp16_t'(bus.thresh_i));
    end
  end

  assign bus.in_ready_o     = (w_stage < STG_W'(NUM_STAGES));
  assign bus.stage_o        = w_stage;
  assign bus.step_o         = r_step;
  assign bus.result_valid_o = w_result_valid;

endmodule

// File: tb/tb_argmax_stage_seq.sv
// Directed bench for argmax_stage_seq: expected results are queued as beats are driven
// and popped when the sequencer offers a result.
module tb_argmax_stage_seq;
  import argmax_pkg::*;

  localparam int LANES       = 2;
  localparam int WIDTH       = 16;
  localparam int IDX_W       = 16;
  localparam int STEP_W      = 8;
  localparam int NUM_STAGES  = 7;
  localparam int TRACK_STAGE = 5;

  localparam logic [55:0] BND_A = {8'd10, 8'd8, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [55:0] BND_C = {8'd255, 8'd8, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [15:0] JUNK  = 16'h7BFF;

  typedef struct {
    string       tag;
    logic [31:0] max;
    logic [31:0] idx;
    logic [1:0]  hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  argmax_stage_seq_if #(
    .LANES(LANES), .WIDTH(WIDTH), .IDX_W(IDX_W), .STEP_W(STEP_W), .NUM_STAGES(NUM_STAGES)
  ) bus ();

  argmax_stage_seq #(
    .LANES(LANES), .WIDTH(WIDTH), .IDX_W(IDX_W), .STEP_W(STEP_W),
    .NUM_STAGES(NUM_STAGES), .TRACK_STAGE(TRACK_STAGE)
  ) dut (
    .CLK_i (clk),
    .RST_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the beat was taken.
  task automatic beat(input logic [15:0] s0, input logic [15:0] p0,
                      input logic [15:0] s1, input logic [15:0] p1);
    int n = 0;
    bus.score_i    = {s1, s0};
    bus.pos_i      = {p1, p0};
    bus.in_valid_i = 1'b1;
    while (bus.in_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic junk_beats(input int n);
    for (int i = 0; i < n; i++) beat(JUNK, 16'hFFFF, JUNK, 16'hFFFF);
  endtask

  task automatic wait_result();
    int n = 0;
    while (bus.result_valid_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("result_valid_wait", 64'(bus.result_valid_o), 64'd1);
  endtask

  task automatic check_result();
    exp_t e;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_max"}, 64'(bus.max_o), 64'(e.max));
      chk({e.tag, "_idx"}, 64'(bus.idx_o), 64'(e.idx));
      chk({e.tag, "_hit"}, 64'(bus.hit_o), 64'(e.hit));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_step"},  64'(bus.step_o),         64'd0);
    chk({tag, "_stage"}, 64'(bus.stage_o),        64'd0);
    chk({tag, "_max"},   64'(bus.max_o),          64'hFC00FC00);
    chk({tag, "_idx"},   64'(bus.idx_o),          64'd0);
    chk({tag, "_rv"},    64'(bus.result_valid_o), 64'd0);
    chk({tag, "_rdy"},   64'(bus.in_ready_o),     64'd1);
    chk({tag, "_hit"},   64'(bus.hit_o),          64'd0);
  endtask

  task automatic release_result(input string tag);
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    bus.in_valid_i     = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                  = 1'b1;
    bus.stage_boundary_i = BND_A;
    bus.thresh_i         = FP16_098;
    bus.in_valid_i       = 1'b0;
    bus.result_ready_i   = 1'b0;
    bus.score_i          = '0;
    bus.pos_i            = '0;

    @(negedge clk);
    check_idle("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_released");

    // Run A: basic max tracking on lane0, equal scores on lane1.
    junk_beats(5);
    chk("a_step5",  64'(bus.step_o),  64'd5);
    chk("a_stage5", 64'(bus.stage_o), 64'd5);
    chk("a_junk_ignored", 64'(bus.max_o), 64'hFC00FC00);
    beat(16'h3800, 16'd3, 16'h3C00, 16'd6);
    chk("a_entry_max", 64'(bus.max_o), 64'h3C003800);
    chk("a_entry_idx", 64'(bus.idx_o), 64'h00060003);
    beat(16'h4000, 16'd4, 16'h3C00, 16'd7);
    chk("a_upd_max", 64'(bus.max_o), 64'h3C004000);
    chk("a_tie_idx", 64'(bus.idx_o), 64'h00060004);
    bus.score_i = {16'h7C00, 16'h7C00};
    repeat (3) @(negedge clk);
    chk("a_stall_step",  64'(bus.step_o),  64'd7);
    chk("a_stall_stage", 64'(bus.stage_o), 64'd5);
    chk("a_stall_max",   64'(bus.max_o),   64'h3C004000);
    beat(16'h3C00, 16'd5, 16'h3000, 16'd8);
    beat(16'h3A00, 16'd6, 16'h3BD7, 16'd9);
    chk("a_stage6", 64'(bus.stage_o), 64'd6);
    junk_beats(1);
    sb.push_back('{tag: "run_a", max: 32'h3C004000, idx: 32'h00060004, hit: 2'b11});
    junk_beats(1);
    wait_result();
    chk("a_step11",   64'(bus.step_o),     64'd11);
    chk("a_stage7",   64'(bus.stage_o),    64'd7);
    chk("a_not_rdy",  64'(bus.in_ready_o), 64'd0);
    check_result();
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("a_hold_rv",   64'(bus.result_valid_o), 64'd1);
      chk("a_hold_max",  64'(bus.max_o),          64'h3C004000);
      chk("a_hold_idx",  64'(bus.idx_o),          64'h00060004);
      chk("a_hold_step", 64'(bus.step_o),         64'd11);
    end
    bus.thresh_i = 16'h3C00;
    #1;
    chk("a_hit_thresh_eq", 64'(bus.hit_o), 64'b01);
    bus.thresh_i = FP16_098;
    #1;
    chk("a_hit_thresh_098", 64'(bus.hit_o), 64'b11);
    release_result("a_restart");

    // Run B: negatives, NaN, signed zeros.
    junk_beats(5);
    beat(16'hBC00, 16'd10, 16'h8000, 16'd20);
    beat(16'h7E00, 16'd11, 16'h0000, 16'd21);
    chk("b_nan_max", 64'(bus.max_o), 64'h8000BC00);
    chk("b_nan_idx", 64'(bus.idx_o), 64'h0014000A);
    beat(16'hC000, 16'd12, 16'h8000, 16'd22);
    beat(16'hFE00, 16'd13, 16'h0000, 16'd23);
    junk_beats(1);
    sb.push_back('{tag: "run_b", max: 32'h8000BC00, idx: 32'h0014000A, hit: 2'b00});
    junk_beats(1);
    wait_result();
    check_result();
    release_result("b_restart");

    // Run C: NaN on entry, infinities, and a 255 boundary that saturates the step.
    bus.stage_boundary_i = BND_C;
    junk_beats(5);
    beat(16'h7E00, 16'd1, 16'h7C00, 16'd5);
    chk("c_nan_entry_max", 64'(bus.max_o), 64'h7C00FC00);
    chk("c_nan_entry_idx", 64'(bus.idx_o), 64'h00050001);
    beat(16'hFC00, 16'd2, 16'h7BFF, 16'd6);
    beat(16'h0400, 16'd3, 16'h7C00, 16'd7);
    sb.push_back('{tag: "run_c", max: 32'h7C000400, idx: 32'h00050003, hit: 2'b10});
    beat(16'h0200, 16'd4, 16'hFC00, 16'd8);
    check_result();
    junk_beats(251);
    chk("c_sat_step",  64'(bus.step_o),         64'd255);
    chk("c_sat_stage", 64'(bus.stage_o),        64'd6);
    chk("c_sat_rdy",   64'(bus.in_ready_o),     64'd1);
    chk("c_sat_rv",    64'(bus.result_valid_o), 64'd0);
    chk("c_sat_max",   64'(bus.max_o),          64'h7C000400);

    // Run D: asynchronous reset in the middle of the tracking stage.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.stage_boundary_i = BND_A;
    junk_beats(5);
    beat(16'h3800, 16'd3, 16'h3000, 16'd1);
    beat(16'h4000, 16'd4, 16'h3400, 16'd2);
    chk("d_pre_reset_max", 64'(bus.max_o), 64'h34004000);
    rst = 1'b1;
    #1;
    check_idle("d_async_reset");
    @(negedge clk);
    rst = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
